// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------+
// | alu_pkg: command encodings and sequencer state encodings shared by the     |
// | ALU, the sequencer and the bench.                             Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_XOR  = 3'b010;
  localparam logic [2:0] CMD_SLT  = 3'b011;
  localparam logic [2:0] CMD_AND  = 3'b100;
  localparam logic [2:0] CMD_NAND = 3'b101;
  localparam logic [2:0] CMD_NOR  = 3'b110;
  localparam logic [2:0] CMD_OR   = 3'b111;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_alu.sv
// +----------------------------------------------------------------------------+
// | alu_sequencer_alu: 32-bit combinational ALU (add/sub/slt/logic) with      |
// | carryout, zero and overflow flags.                            Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_sequencer_alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  cmd,
  output logic [31:0] result,
  output logic        carryout,
  output logic        zero,
  output logic        overflow
);

  logic        cin;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        sum_ovf;

  // SLT shares the subtract path: sign of A-B corrected by overflow.
  always_comb begin
    cin      = (cmd != CMD_ADD);
    b_eff    = cin ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {32'b0, cin};
    sum_ovf  = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    result   = '0;
    carryout = 1'b0;
    zero     = 1'b0;
    overflow = 1'b0;
    case (cmd)
      CMD_ADD, CMD_SUB: begin
        result   = sum[31:0];
        carryout = sum[32];
        overflow = sum_ovf;
        zero     = (sum[31:0] == 32'd0);
      end
      CMD_SLT:  result = {31'd0, sum[31] ^ sum_ovf};
      CMD_XOR:  result = a ^ b;
      CMD_AND:  result = a & b;
      CMD_NAND: result = ~(a & b);
      CMD_NOR:  result = ~(a | b);
      default:  result = a | b;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// +----------------------------------------------------------------------------+
// | alu_sequencer: holds a request on the ALU for SETTLE_CYCLES, then captures |
// | the result into a valid/ready response. Option: ALU_SEQ_STICKY_FLAGS_EN.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_cmd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_carryout,
  output logic        resp_zero,
  output logic        resp_overflow
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  ,
  input  logic        sticky_clear,
  output logic        sticky_overflow,
  output logic        sticky_carryout
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      result_q, result_d;
  logic             carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;
  logic             capture;

  logic [31:0]      alu_result;
  logic             alu_carry, alu_zero, alu_ovf;

  alu_sequencer_alu u_alu (
    .a        (a_q),
    .b        (b_q),
    .cmd      (cmd_q),
    .result   (alu_result),
    .carryout (alu_carry),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    cmd_d        = cmd_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d         = req_a;
          b_d         = req_b;
          cmd_d       = req_cmd;
          cnt_d       = SETTLE_LOAD;
          req_ready_d = 1'b0;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          capture      = 1'b1;
          result_d     = alu_result;
          carry_d      = alu_carry;
          zero_d       = alu_zero;
          ovf_d        = alu_ovf;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        // Returning to IDLE only re-opens req_ready for the following edge.
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cmd_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cmd_q        <= cmd_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_result   = result_q;
  assign resp_carryout = carry_q;
  assign resp_zero     = zero_q;
  assign resp_overflow = ovf_q;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic sticky_ovf_q, sticky_ovf_d, sticky_carry_q, sticky_carry_d;

  // A capture setting the flag wins over a simultaneous clear.
  always_comb begin
    sticky_ovf_d   = (sticky_ovf_q & ~sticky_clear) | (capture & alu_ovf);
    sticky_carry_d = (sticky_carry_q & ~sticky_clear) | (capture & alu_carry);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_ovf_q   <= 1'b0;
      sticky_carry_q <= 1'b0;
    end else begin
      sticky_ovf_q   <= sticky_ovf_d;
      sticky_carry_q <= sticky_carry_d;
    end
  end

  assign sticky_overflow = sticky_ovf_q;
  assign sticky_carryout = sticky_carry_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_alu_sequencer: scoreboard bench for alu_sequencer; sticky checks when   |
// | ALU_SEQ_STICKY_FLAGS_EN is defined.                           Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int SETTLE = 4;
  localparam longint S32_MAX = 64'sd2147483647;
  localparam longint S32_MIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_a, req_b, resp_result;
  logic [2:0]  req_cmd;
  logic        resp_carryout, resp_zero, resp_overflow;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
  logic        sticky_clear, sticky_overflow, sticky_carryout;
`endif

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        o;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rr_mode = 0;

  alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_cmd       (req_cmd),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .resp_carryout (resp_carryout),
    .resp_zero     (resp_zero),
    .resp_overflow (resp_overflow)
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    ,
    .sticky_clear    (sticky_clear),
    .sticky_overflow (sticky_overflow),
    .sticky_carryout (sticky_carryout)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic c, z, o);
    exp_t e;
    e.r = r; e.c = c; e.z = z; e.o = o; e.acc = 0;
    return e;
  endfunction

  // Reference: plain wide arithmetic on the operand values.
  function automatic exp_t model(input logic [31:0] a, b, input logic [2:0] cmd);
    exp_t e;
    longint sa, sb, sr;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e = mk(32'd0, 1'b0, 1'b0, 1'b0);
    case (cmd)
      CMD_ADD: begin
        e.r = a + b;
        e.c = (ua + ub) > 64'hFFFF_FFFF;
        sr  = sa + sb;
        e.o = (sr > S32_MAX) || (sr < S32_MIN);
        e.z = (e.r == 32'd0);
      end
      CMD_SUB: begin
        e.r = a - b;
        e.c = (a >= b);
        sr  = sa - sb;
        e.o = (sr > S32_MAX) || (sr < S32_MIN);
        e.z = (a == b);
      end
      CMD_SLT:  e.r = (sa < sb) ? 32'd1 : 32'd0;
      CMD_XOR:  e.r = a ^ b;
      CMD_AND:  e.r = a & b;
      CMD_NAND: e.r = ~(a & b);
      CMD_NOR:  e.r = ~(a | b);
      default:  e.r = a | b;
    endcase
    return e;
  endfunction

  initial resp_ready = 1'b0;
  always @(posedge clk) begin
    #2;
    case (rr_mode)
      0:       resp_ready = ($urandom_range(0, 2) != 0);
      1:       resp_ready = 1'b0;
      default: resp_ready = 1'b1;
    endcase
  end

  // Monitor: one scoreboard pop per new response, plus hold/handshake checks.
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] hr = 32'd0;
  logic        hc = 1'b0, hz = 1'b0, ho = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      pv = 1'b0; pr = 1'b0; hr = 32'd0; hc = 1'b0; hz = 1'b0; ho = 1'b0;
    end else begin
      if (pv && pr) begin
        check1("ack_to_idle_valid", resp_valid, 1'b0);
        check1("ack_to_idle_ready", req_ready, 1'b1);
      end else if (pv) begin
        check1("resp_held_valid", resp_valid, 1'b1);
      end
      if (resp_valid && !pv) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: got result %h expected no response", resp_result);
        end else begin
          e = sbq.pop_front();
          check("result", resp_result, e.r);
          check1("carryout", resp_carryout, e.c);
          check1("zero", resp_zero, e.z);
          check1("overflow", resp_overflow, e.o);
          check("latency", 32'(cyc - e.acc), 32'(SETTLE));
        end
        hr = resp_result; hc = resp_carryout; hz = resp_zero; ho = resp_overflow;
      end else begin
        check("hold_result", resp_result, hr);
        check1("hold_flags", resp_carryout | resp_zero | resp_overflow, hc | hz | ho);
        if (resp_valid) check1("resp_req_ready_low", req_ready, 1'b0);
      end
      pv = resp_valid;
      pr = resp_ready;
    end
  end

  task automatic drive_noise();
    if (req_ready) begin
      req_valid = 1'b0;
    end else begin
      req_valid = 1'($urandom_range(0, 1));
      req_a     = $urandom;
      req_b     = $urandom;
      req_cmd   = 3'($urandom);
    end
  endtask

  task automatic send(input logic [31:0] a, b, input logic [2:0] cmd,
                      input bit use_lit, input exp_t lit);
    exp_t e;
    bit   done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (req_ready && !reset) begin
        req_valid = 1'b1; req_a = a; req_b = b; req_cmd = cmd;
        e     = use_lit ? lit : model(a, b, cmd);
        e.acc = cyc + 1;
        sbq.push_back(e);
        done  = 1'b1;
      end else begin
        drive_noise();
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: got req_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic send_lit(input logic [31:0] a, b, input logic [2:0] cmd,
                          input logic [31:0] r, input logic c, z, o);
    send(a, b, cmd, 1'b1, mk(r, c, z, o));
  endtask

  task automatic send_rand(input logic [31:0] a, b, input logic [2:0] cmd);
    send(a, b, cmd, 1'b0, mk(32'd0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      drive_noise();
      if (sbq.size() == 0 && req_ready) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_resp_valid"}, resp_valid, 1'b0);
    check1({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_resp_result"}, resp_result, 32'd0);
    check1({tag, "_flags"}, resp_carryout | resp_zero | resp_overflow, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit bp_seen;
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cmd = '0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    sticky_clear = 1'b0;
`endif
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    send_lit(32'h0003_0D40, 32'h0000_4E20, CMD_ADD, 32'h0003_5B60, 1'b0, 1'b0, 1'b0);
    send_lit(32'h0BEB_C200, 32'h88CA_6C00, CMD_SUB, 32'h8321_5600, 1'b0, 1'b0, 1'b1);
    send_lit(32'h0001_86A0, 32'h0001_86A0, CMD_SUB, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    send_lit(32'd3, 32'd5, CMD_XOR,  32'd6,         1'b0, 1'b0, 1'b0);
    send_lit(32'd3, 32'd5, CMD_SLT,  32'd1,         1'b0, 1'b0, 1'b0);
    send_lit(32'd3, 32'd5, CMD_AND,  32'd1,         1'b0, 1'b0, 1'b0);
    send_lit(32'd3, 32'd5, CMD_NAND, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send_lit(32'd3, 32'd5, CMD_NOR,  32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0);
    send_lit(32'd3, 32'd5, CMD_OR,   32'd7,         1'b0, 1'b0, 1'b0);
    wait_drain();

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, b;
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? a : pick();
      send_rand(a, b, 3'($urandom));
    end
    wait_drain();

    // Backpressure: response held for 10 cycles while req_* toggle.
    rr_mode = 1;
    send_lit(32'h1234_5678, 32'h0000_0001, CMD_ADD, 32'h1234_5679, 1'b0, 1'b0, 1'b0);
    bp_seen = 1'b0;
    for (int i = 0; i < 50 && !bp_seen; i++) begin
      @(negedge clk);
      drive_noise();
      bp_seen = resp_valid;
    end
    check1("bp_resp_valid", bp_seen, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_noise();
    end
    rr_mode = 2;
    wait_drain();
    rr_mode = 0;

    // Reset in the middle of EXEC discards the operation.
    send_rand(32'hDEAD_BEEF, 32'h0000_1111, CMD_SUB);
    @(negedge clk); drive_noise();
    @(negedge clk); drive_noise();
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midexec");
    sbq.delete();
    req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    send_lit(32'hFFFF_FFFF, 32'h0000_0001, CMD_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    wait_drain();

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    @(negedge clk); sticky_clear = 1'b1;
    @(negedge clk); sticky_clear = 1'b0;
    check1("sticky_ov_cleared0", sticky_overflow, 1'b0);
    check1("sticky_cy_cleared0", sticky_carryout, 1'b0);
    send_lit(32'h0BEB_C200, 32'h88CA_6C00, CMD_SUB, 32'h8321_5600, 1'b0, 1'b0, 1'b1);
    wait_drain();
    check1("sticky_ov_set", sticky_overflow, 1'b1);
    send_lit(32'd1, 32'd2, CMD_ADD, 32'd3, 1'b0, 1'b0, 1'b0);
    wait_drain();
    check1("sticky_ov_kept", sticky_overflow, 1'b1);
    check1("sticky_cy_clear", sticky_carryout, 1'b0);
    @(negedge clk); sticky_clear = 1'b1;
    @(negedge clk); sticky_clear = 1'b0;
    check1("sticky_ov_cleared", sticky_overflow, 1'b0);
`endif

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
